// File: rtl/multicycle_ctrl_pkg.sv
// Shared processor definitions: controller state encoding, decoded instruction
// classes and PC source selects used by decode, the PC unit and the controller.
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6,
      ST_FAULT  = 3'd7
   } state_e;

   typedef enum logic [2:0] {
      CLS_RTYPE  = 3'd0,
      CLS_ITYPE  = 3'd1,
      CLS_LOAD   = 3'd2,
      CLS_STORE  = 3'd3,
      CLS_BRANCH = 3'd4,
      CLS_JUMP   = 3'd5,
      CLS_JAL    = 3'd6,
      CLS_HALT   = 3'd7
   } inst_class_e;

   typedef enum logic [1:0] {
      PC_PLUS1  = 2'd0,
      PC_BRANCH = 2'd1,
      PC_JUMP   = 2'd2
   } pc_src_e;

   // Wide enough for the largest allowed TIMEOUT (255).
   localparam int WAIT_W = 8;

   function automatic logic is_mem_class(input inst_class_e c);
      return (c == CLS_LOAD) || (c == CLS_STORE);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Memory-acknowledge wait timer: counts unacknowledged request cycles and flags
// the cycle in which the TIMEOUT-th consecutive cycle without ack is reached.
module mem_wait_timer
   import multicycle_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [WAIT_W-1:0] LAST = WAIT_W'(TIMEOUT - 1);

   logic [WAIT_W-1:0] count_q;
   logic [WAIT_W-1:0] count_d;

   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !expired) begin
         count_d = count_q + WAIT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: sequences fetch/decode/execute/memory/
// writeback, drives datapath strobes and counts retired instructions.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [2:0]       inst_class,
   input  logic             branch_taken,
   input  logic             mem_ack,
   output logic             mem_req,
   output logic             mem_sel,
   output logic             mem_we,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic             rf_we,
   output logic             link_sel,
   output logic             busy,
   output logic             halted,
   output logic             fault,
   output logic [CNT_W-1:0] retired
);

   state_e            state_q, state_d;
   inst_class_e       cls_q, cls_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   pc_src_e           pc_src_sel;
   logic              waiting;
   logic              expired;
   logic              halt_go;

   // The timer restarts whenever the current memory transaction is not pending.
   assign waiting = (state_q == ST_FETCH) || (state_q == ST_MEM);

   mem_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (!waiting || mem_ack),
      .enable  (waiting && !mem_ack),
      .expired (expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (run) state_d = ST_FETCH;
         ST_FETCH: begin
            if (mem_ack)      state_d = ST_DECODE;
            else if (expired) state_d = ST_FAULT;
         end
         ST_DECODE: state_d = ST_EXEC;
         ST_EXEC: begin
            case (cls_q)
               CLS_RTYPE, CLS_ITYPE: state_d = ST_WB;
               CLS_LOAD, CLS_STORE:  state_d = ST_MEM;
               CLS_HALT:             state_d = ST_HALT;
               default:              state_d = ST_FETCH;
            endcase
         end
         ST_MEM: begin
            if (mem_ack)      state_d = (cls_q == CLS_STORE) ? ST_FETCH : ST_WB;
            else if (expired) state_d = ST_FAULT;
         end
         ST_WB:     state_d = ST_FETCH;
         default:   state_d = state_q;
      endcase
   end

   always_comb begin
      mem_req    = 1'b0;
      mem_sel    = 1'b0;
      mem_we     = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src_sel = PC_PLUS1;
      rf_we      = 1'b0;
      link_sel   = 1'b0;
      busy       = 1'b0;
      halted     = 1'b0;
      fault      = 1'b0;
      case (state_q)
         ST_FETCH: begin
            busy    = 1'b1;
            mem_req = 1'b1;
            ir_we   = mem_ack;
         end
         ST_DECODE: busy = 1'b1;
         ST_EXEC: begin
            busy = 1'b1;
            case (cls_q)
               CLS_BRANCH: begin
                  pc_we      = 1'b1;
                  pc_src_sel = branch_taken ? PC_BRANCH : PC_PLUS1;
               end
               CLS_JUMP: begin
                  pc_we      = 1'b1;
                  pc_src_sel = PC_JUMP;
               end
               CLS_JAL: begin
                  pc_we      = 1'b1;
                  pc_src_sel = PC_JUMP;
                  rf_we      = 1'b1;
                  link_sel   = 1'b1;
               end
               default: ;
            endcase
         end
         ST_MEM: begin
            busy    = 1'b1;
            mem_req = 1'b1;
            mem_sel = 1'b1;
            mem_we  = (cls_q == CLS_STORE);
            pc_we   = mem_ack && (cls_q == CLS_STORE);
         end
         ST_WB: begin
            busy  = 1'b1;
            rf_we = 1'b1;
            pc_we = 1'b1;
         end
         ST_HALT:  halted = 1'b1;
         ST_FAULT: fault  = 1'b1;
         default: ;
      endcase
   end

   assign pc_src  = pc_src_sel;
   assign halt_go = (state_q == ST_EXEC) && (cls_q == CLS_HALT);

   // The class is captured with the instruction word; later phases only see the copy.
   always_comb begin
      cls_d     = ir_we ? inst_class_e'(inst_class) : cls_q;
      retired_d = retired_q;
      if (pc_we || halt_go) begin
         retired_d = retired_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cls_q     <= CLS_RTYPE;
         retired_q <= '0;
      end else begin
         cls_q     <= cls_d;
         retired_q <= retired_d;
      end
   end

   assign retired = retired_q;

   logic unused_ok;
   assign unused_ok = is_mem_class(cls_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: randomized instruction streams
// compared cycle by cycle against a per-instruction phase model.
module tb_multicycle_ctrl;

   localparam int TIMEOUT = 16;

   localparam logic [2:0] C_R = 3'd0, C_I = 3'd1, C_LD = 3'd2, C_ST = 3'd3;
   localparam logic [2:0] C_BR = 3'd4, C_J = 3'd5, C_JAL = 3'd6, C_HLT = 3'd7;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic [2:0] inst_class = 3'd0;
   logic       branch_taken = 1'b0;
   logic       mem_ack = 1'b0;

   logic        mem_req, mem_sel, mem_we, ir_we, pc_we, rf_we, link_sel, busy, halted, fault;
   logic [1:0]  pc_src;
   logic [31:0] retired;

   logic        mem_req4, mem_sel4, mem_we4, ir_we4, pc_we4, rf_we4, link_sel4, busy4, halted4, fault4;
   logic [1:0]  pc_src4;
   logic [3:0]  retired4;

   multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .run(run), .inst_class(inst_class),
      .branch_taken(branch_taken), .mem_ack(mem_ack),
      .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we), .ir_we(ir_we),
      .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we), .link_sel(link_sel),
      .busy(busy), .halted(halted), .fault(fault), .retired(retired)
   );

   multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .run(run), .inst_class(inst_class),
      .branch_taken(branch_taken), .mem_ack(mem_ack),
      .mem_req(mem_req4), .mem_sel(mem_sel4), .mem_we(mem_we4), .ir_we(ir_we4),
      .pc_we(pc_we4), .pc_src(pc_src4), .rf_we(rf_we4), .link_sel(link_sel4),
      .busy(busy4), .halted(halted4), .fault(fault4), .retired(retired4)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       mem_req;
      logic       mem_sel;
      logic       mem_we;
      logic       ir_we;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       rf_we;
      logic       link_sel;
      logic       busy;
      logic       halted;
      logic       fault;
   } outs_t;

   typedef struct {
      logic       ack;
      logic [2:0] cls;
      logic       taken;
      logic       run;
      outs_t      exp;
      bit         ret;
      string      ph;
   } cyc_t;

   int checks = 0;
   int errors = 0;
   int retired_m = 0;

   function automatic outs_t obs();
      outs_t o;
      o = '{mem_req, mem_sel, mem_we, ir_we, pc_we, pc_src, rf_we, link_sel, busy, halted, fault};
      return o;
   endfunction

   function automatic outs_t obs4();
      outs_t o;
      o = '{mem_req4, mem_sel4, mem_we4, ir_we4, pc_we4, pc_src4, rf_we4, link_sel4, busy4, halted4, fault4};
      return o;
   endfunction

   // Busy cycle with don't-care inputs randomized, since they must be ignored.
   function automatic cyc_t rnd_cyc(input string ph);
      cyc_t c;
      c.ack      = 1'($urandom);
      c.cls      = 3'($urandom);
      c.taken    = 1'($urandom);
      c.run      = 1'($urandom);
      c.exp      = '0;
      c.exp.busy = 1'b1;
      c.ret      = 1'b0;
      c.ph       = ph;
      return c;
   endfunction

   task automatic drive(input logic ack, input logic [2:0] cls, input logic tk, input logic rn);
      @(negedge clk);
      mem_ack      = ack;
      inst_class   = cls;
      branch_taken = tk;
      run          = rn;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run = 1'b0;
      mem_ack = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      retired_m = 0;
   endtask

   task automatic start_run();
      drive(1'($urandom), 3'($urandom), 1'($urandom), 1'b1);
   endtask

   // f_lat / m_lat: cycle of the ack (1 = ack in entry cycle); 0 = never acked.
   task automatic exec_instr(input logic [2:0] cls, input int f_lat, input int m_lat,
                             input logic taken, input string tag);
      cyc_t q[$];
      cyc_t c;
      int   n;
      n = (f_lat == 0) ? TIMEOUT : f_lat;
      for (int i = 1; i <= n; i++) begin
         c = rnd_cyc("fetch");
         c.ack = (i == f_lat);
         c.exp.mem_req = 1'b1;
         c.exp.ir_we = c.ack;
         if (c.ack) c.cls = cls;
         q.push_back(c);
      end
      if (f_lat != 0) begin
         q.push_back(rnd_cyc("decode"));
         c = rnd_cyc("exec");
         if (cls == C_BR) begin
            c.taken = taken;
            c.exp.pc_we = 1'b1;
            c.exp.pc_src = {1'b0, taken};
         end else if (cls == C_J || cls == C_JAL) begin
            c.exp.pc_we = 1'b1;
            c.exp.pc_src = 2'd2;
            c.exp.rf_we = (cls == C_JAL);
            c.exp.link_sel = (cls == C_JAL);
         end
         c.ret = (cls >= C_BR);
         q.push_back(c);
         if (cls == C_LD || cls == C_ST) begin
            n = (m_lat == 0) ? TIMEOUT : m_lat;
            for (int j = 1; j <= n; j++) begin
               c = rnd_cyc("mem");
               c.ack = (j == m_lat);
               c.exp.mem_req = 1'b1;
               c.exp.mem_sel = 1'b1;
               c.exp.mem_we = (cls == C_ST);
               c.exp.pc_we = c.ack && (cls == C_ST);
               c.ret = c.exp.pc_we;
               q.push_back(c);
            end
         end
         if (cls == C_R || cls == C_I || (cls == C_LD && m_lat != 0)) begin
            c = rnd_cyc("wb");
            c.exp.rf_we = 1'b1;
            c.exp.pc_we = 1'b1;
            c.ret = 1'b1;
            q.push_back(c);
         end
      end
      foreach (q[k]) begin
         drive(q[k].ack, q[k].cls, q[k].taken, q[k].run);
         checks++;
         if (obs() !== q[k].exp) begin
            errors++;
            $display("FAIL %s/%s[%0d] outputs got=%b exp=%b", tag, q[k].ph, k, obs(), q[k].exp);
         end
         checks++;
         if (obs4() !== q[k].exp) begin
            errors++;
            $display("FAIL %s/%s[%0d] outputs4 got=%b exp=%b", tag, q[k].ph, k, obs4(), q[k].exp);
         end
         checks++;
         if (retired !== 32'(retired_m) || retired4 !== 4'(retired_m)) begin
            errors++;
            $display("FAIL %s/%s[%0d] retired got=%0d/%0d exp=%0d", tag, q[k].ph, k,
                     retired, retired4, retired_m);
         end
         if (q[k].ret) retired_m++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++;
      if (obs() !== '0 || retired !== '0) begin
         errors++;
         $display("FAIL reset_state got=%b/%0d exp=0/0", obs(), retired);
      end
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'($urandom), 3'($urandom), 1'($urandom), 1'b0);
         checks++;
         if (obs() !== '0 || retired !== '0) begin
            errors++;
            $display("FAIL idle_no_run[%0d] got=%b/%0d exp=0/0", i, obs(), retired);
         end
      end
   endtask

   task automatic test_alu();
      do_reset();
      start_run();
      exec_instr(C_R, 1, 0, 1'b0, "add");
      @(posedge clk);
      #1;
      checks++;
      if (retired !== 32'd1) begin
         errors++;
         $display("FAIL add_retired got=%0d exp=1", retired);
      end
      exec_instr(C_I, $urandom_range(1, 5), 0, 1'b0, "itype");
   endtask

   task automatic test_load_store();
      do_reset();
      start_run();
      exec_instr(C_LD, $urandom_range(1, 4), 3, 1'b0, "load");
      exec_instr(C_ST, $urandom_range(1, 4), $urandom_range(1, 6), 1'b0, "store");
      exec_instr(C_LD, TIMEOUT, TIMEOUT, 1'b0, "load_max_lat");
   endtask

   task automatic test_branch_jump();
      do_reset();
      start_run();
      exec_instr(C_BR, $urandom_range(1, 3), 0, 1'b1, "br_taken");
      exec_instr(C_BR, $urandom_range(1, 3), 0, 1'b0, "br_not_taken");
      exec_instr(C_J, $urandom_range(1, 3), 0, 1'b0, "jump");
      exec_instr(C_JAL, $urandom_range(1, 3), 0, 1'b0, "jal");
   endtask

   task automatic test_halt();
      outs_t e;
      do_reset();
      start_run();
      exec_instr(C_R, 2, 0, 1'b0, "pre_halt");
      exec_instr(C_HLT, 1, 0, 1'b0, "halt");
      e = '0;
      e.halted = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'($urandom), 3'($urandom), 1'($urandom), 1'b1);
         checks++;
         if (obs() !== e || retired !== 32'd2) begin
            errors++;
            $display("FAIL halt_sticky[%0d] got=%b/%0d exp=%b/2", i, obs(), retired, e);
         end
      end
   endtask

   task automatic test_timeout();
      outs_t e;
      e = '0;
      e.fault = 1'b1;
      for (int r = 0; r < 2; r++) begin
         do_reset();
         start_run();
         if (r == 0) exec_instr(C_R, 0, 0, 1'b0, "fetch_timeout");
         else        exec_instr(C_LD, 2, 0, 1'b0, "mem_timeout");
         for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 3'($urandom), 1'($urandom), 1'b1);
            checks++;
            if (obs() !== e) begin
               errors++;
               $display("FAIL fault_sticky[%0d.%0d] got=%b exp=%b", r, i, obs(), e);
            end
         end
      end
   endtask

   task automatic test_reset_mid_mem();
      do_reset();
      start_run();
      exec_instr(C_R, 1, 0, 1'b0, "pre_reset");
      drive(1'b1, C_LD, 1'b0, 1'b0);
      drive(1'b0, 3'd0, 1'b0, 1'b0);
      drive(1'b0, 3'd0, 1'b0, 1'b0);
      drive(1'b0, 3'd0, 1'b0, 1'b0);
      checks++;
      if (mem_req !== 1'b1 || mem_sel !== 1'b1 || retired !== 32'd1) begin
         errors++;
         $display("FAIL pre_reset_mem got=%b%b/%0d exp=11/1", mem_req, mem_sel, retired);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (obs() !== '0 || retired !== '0 || retired4 !== '0) begin
         errors++;
         $display("FAIL async_reset got=%b/%0d exp=0/0", obs(), retired);
      end
      do_reset();
      drive(1'b1, 3'd0, 1'b0, 1'b0);
      checks++;
      if (obs() !== '0) begin
         errors++;
         $display("FAIL idle_after_reset got=%b exp=0", obs());
      end
   endtask

   task automatic test_wrap();
      do_reset();
      start_run();
      for (int i = 0; i < 17; i++) begin
         exec_instr(3'($urandom_range(0, 6)), $urandom_range(1, 3), $urandom_range(1, 3),
                    1'($urandom), "wrap");
      end
      @(posedge clk);
      #1;
      checks++;
      if (retired4 !== 4'd1 || retired !== 32'd17) begin
         errors++;
         $display("FAIL wrap got=%0d/%0d exp=1/17", retired4, retired);
      end
   endtask

   task automatic test_random();
      do_reset();
      start_run();
      for (int i = 0; i < 25; i++) begin
         exec_instr(3'($urandom_range(0, 6)), $urandom_range(1, TIMEOUT),
                    $urandom_range(1, TIMEOUT), 1'($urandom), "random");
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_store();
      test_branch_jump();
      test_halt();
      test_timeout();
      test_reset_mid_mem();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
